// File: rtl/pipeline_sequencer.sv
// Pipeline sequencer for the 5-stage RV32 core: per-stage enables/flushes for load-use,
// EX redirects, data-memory waits and HALT drain, plus saturating stall/flush counters.
module pipeline_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             id_halt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic             memwb_bubble,
    output logic             halted,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [DW-1:0]    drain_cnt_r;
    logic [DW-1:0]    drain_nxt_s;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;
    logic             stall_inc_s;
    logic             flush_inc_s;
    logic             mem_wait_s;
    logic             load_use_s;

    assign mem_wait_s = mem_req & ~mem_ready;
    assign load_use_s = ex_memread & (ex_rd != 5'd0) &
                        ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                         (id_uses_rs2 & (id_rs2 == ex_rd)));

    assign stall_count = stall_cnt_r;
    assign flush_count = flush_cnt_r;

    // Next-state, drain countdown and per-stage control, by priority of events.
    always_comb begin
        state_nxt_s  = state_r;
        drain_nxt_s  = drain_cnt_r;
        stall_inc_s  = 1'b0;
        flush_inc_s  = 1'b0;
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        pipe_hold    = 1'b0;
        memwb_bubble = 1'b0;
        halted       = 1'b0;
        if (reset) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else begin
            case (state_r)
                ST_RUN: begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    if (mem_wait_s) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        pipe_hold    = 1'b1;
                        memwb_bubble = 1'b1;
                        stall_inc_s  = 1'b1;
                    end else if (ex_redirect) begin
                        // Wrong-path HALT or hazard in ID is squashed by the flush.
                        ifid_flush  = 1'b1;
                        idex_flush  = 1'b1;
                        flush_inc_s = 1'b1;
                    end else if (id_halt) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_flush  = 1'b1;
                        stall_inc_s = 1'b1;
                        state_nxt_s = ST_DRAIN;
                        drain_nxt_s = DW'(DRAIN_CYCLES - 1);
                    end else if (load_use_s) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_flush  = 1'b1;
                        stall_inc_s = 1'b1;
                    end else begin
                        stall_inc_s = 1'b0;
                    end
                end
                ST_DRAIN: begin
                    idex_flush = 1'b1;
                    if (mem_wait_s) begin
                        pipe_hold    = 1'b1;
                        memwb_bubble = 1'b1;
                    end else if (drain_cnt_r == '0) begin
                        state_nxt_s = ST_HALTED;
                    end else begin
                        drain_nxt_s = drain_cnt_r - DW'(1);
                    end
                end
                ST_HALTED: begin
                    ifid_flush   = 1'b1;
                    idex_flush   = 1'b1;
                    memwb_bubble = 1'b1;
                    halted       = 1'b1;
                end
                default: begin
                    ifid_flush   = 1'b1;
                    idex_flush   = 1'b1;
                    memwb_bubble = 1'b1;
                    state_nxt_s  = ST_RUN;
                    drain_nxt_s  = '0;
                end
            endcase
        end
    end

    // State, drain counter and saturating performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_RUN;
            drain_cnt_r <= '0;
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            state_r     <= state_nxt_s;
            drain_cnt_r <= drain_nxt_s;
            if (stall_inc_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if (flush_inc_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: a reference model pushes expected controls and
// counters per cycle; they are popped and compared against the DUT mid-cycle.
module tb_pipeline_sequencer;

    localparam int DC   = 3;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic [6:0]    ctl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_uses_rs1, id_uses_rs2, id_halt, ex_memread, ex_redirect;
    logic          mem_req, mem_ready;
    logic          pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, memwb_bubble, halted;
    logic [CW-1:0] stall_count, flush_count;

    int   total = 0;
    int   bad   = 0;
    int   m_state = 0;
    int   m_drain = 0;
    int   m_stall = 0;
    int   m_flush = 0;
    logic [6:0] obs_ctl;
    logic       prev_halted;
    exp_t q[$];

    always #5 clk = ~clk;

    pipeline_sequencer #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_halt(id_halt), .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .pipe_hold(pipe_hold), .memwb_bubble(memwb_bubble),
        .halted(halted), .stall_count(stall_count), .flush_count(flush_count)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr_in();
        reset = 1'b0; id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; id_halt = 1'b0; ex_memread = 1'b0;
        ex_redirect = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    // ctl bit order: {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, memwb_bubble, halted}
    task automatic model_out(output logic [6:0] o);
        logic mw, lu;
        mw = mem_req && !mem_ready;
        lu = ex_memread && (ex_rd != 5'd0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        if (reset)                o = 7'b0011010;
        else if (m_state == 2)    o = 7'b0011011;
        else if (m_state == 1)    o = mw ? 7'b0001110 : 7'b0001000;
        else if (mw)              o = 7'b0000110;
        else if (ex_redirect)     o = 7'b1111000;
        else if (id_halt || lu)   o = 7'b0001000;
        else                      o = 7'b1100000;
    endtask

    task automatic model_step();
        logic mw, lu;
        mw = mem_req && !mem_ready;
        lu = ex_memread && (ex_rd != 5'd0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        if (reset) begin
            m_state = 0; m_drain = 0; m_stall = 0; m_flush = 0;
        end else if (m_state == 0) begin
            if (mw || (!ex_redirect && (id_halt || lu))) begin
                if (m_stall < CMAX) m_stall++;
            end else if (ex_redirect) begin
                if (m_flush < CMAX) m_flush++;
            end
            if (!mw && !ex_redirect && id_halt) begin
                m_state = 1; m_drain = DC - 1;
            end
        end else if (m_state == 1 && !mw) begin
            if (m_drain == 0) m_state = 2;
            else m_drain--;
        end
    endtask

    task automatic cycle();
        exp_t e, g;
        logic [6:0] o;
        model_out(o);
        e.ctl = o; e.sc = m_stall[CW-1:0]; e.fc = m_flush[CW-1:0];
        q.push_back(e);
        @(negedge clk);
        prev_halted = obs_ctl[0];
        obs_ctl = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, memwb_bubble, halted};
        g = q.pop_front();
        check_val("ctl", {25'd0, obs_ctl}, {25'd0, g.ctl});
        check_val("stall_count", {28'd0, stall_count}, {28'd0, g.sc});
        check_val("flush_count", {28'd0, flush_count}, {28'd0, g.fc});
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        obs_ctl = 7'd0;
        prev_halted = 1'b0;
        clr_in();
        reset = 1'b1;
        @(posedge clk); #1;
        cycle(); cycle();
        check_val("reset_ctl", {25'd0, obs_ctl}, 32'h1a);
        clr_in(); cycle();
        check_val("idle_ctl", {25'd0, obs_ctl}, 32'h60);

        // load-use on rs1
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        cycle();
        check_val("lu_ctl", {25'd0, obs_ctl}, 32'h08);
        clr_in(); cycle();
        check_val("lu_stall", {28'd0, stall_count}, 32'd1);
        check_val("lu_after", {25'd0, obs_ctl}, 32'h60);

        // load to x0: no hazard
        ex_memread = 1'b1; id_uses_rs1 = 1'b1; cycle();
        check_val("x0_pc", {31'd0, pc_write}, 32'd1);
        clr_in(); id_uses_rs2 = 1'b1; id_rs2 = 5'd7; ex_rd = 5'd7; ex_memread = 1'b1; cycle();
        check_val("lu_rs2", {25'd0, obs_ctl}, 32'h08);

        // redirect over load-use hazard and halt
        clr_in(); ex_memread = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        id_halt = 1'b1; ex_redirect = 1'b1; cycle();
        check_val("redir_ctl", {25'd0, obs_ctl}, 32'h78);
        clr_in(); cycle();
        check_val("redir_flush", {28'd0, flush_count}, 32'd1);
        check_val("redir_run", {25'd0, obs_ctl}, 32'h60);

        // memory wait hides redirect for 3 cycles
        ex_redirect = 1'b1; mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_val("mw_ctl", {25'd0, obs_ctl}, 32'h06);
        end
        mem_ready = 1'b1; cycle();
        check_val("mw_release", {25'd0, obs_ctl}, 32'h78);
        clr_in(); cycle();
        check_val("mw_stall", {28'd0, stall_count}, 32'd5);
        check_val("mw_flush", {28'd0, flush_count}, 32'd2);

        // counter saturation
        ex_memread = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1'b1;
        for (int i = 0; i < 14; i++) cycle();
        clr_in(); ex_redirect = 1'b1;
        for (int i = 0; i < 16; i++) cycle();
        clr_in(); cycle();
        check_val("stall_sat", {28'd0, stall_count}, CMAX);
        check_val("flush_sat", {28'd0, flush_count}, CMAX);

        // halt drain: 3 DRAIN cycles, halted on the 4th after HALT
        id_halt = 1'b1; cycle();
        clr_in(); cycle(); cycle(); cycle();
        check_val("drain_not_yet", {31'd0, obs_ctl[0]}, 32'd0);
        cycle();
        check_val("drain_halted", {31'd0, obs_ctl[0]}, 32'd1);
        ex_redirect = 1'b1; cycle();
        check_val("halted_sticky", {25'd0, obs_ctl}, 32'h1b);

        // reset pulse out of HALTED
        clr_in(); reset = 1'b1; cycle();
        clr_in(); cycle();
        check_val("rst_pc", {31'd0, pc_write}, 32'd1);
        check_val("rst_halted", {31'd0, halted}, 32'd0);
        check_val("rst_stall", {28'd0, stall_count}, 32'd0);
        check_val("rst_flush", {28'd0, flush_count}, 32'd0);

        // halt drain with a one-cycle memory wait mid-drain
        id_halt = 1'b1; cycle();
        clr_in(); cycle();
        mem_req = 1'b1; cycle();
        check_val("dmw_ctl", {25'd0, obs_ctl}, 32'h0e);
        clr_in(); cycle(); cycle();
        check_val("dmw_not_yet", {31'd0, obs_ctl[0]}, 32'd0);
        cycle();
        check_val("dmw_halted", {31'd0, obs_ctl[0]}, 32'd1);
        check_val("dmw_edge", {31'd0, prev_halted}, 32'd0);

        // randomized traffic checked by the model
        clr_in(); reset = 1'b1; cycle();
        for (int i = 0; i < 300; i++) begin
            clr_in();
            reset       = ($urandom_range(0, 39) == 0);
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom_range(0, 1));
            id_uses_rs2 = 1'($urandom_range(0, 1));
            ex_memread  = 1'($urandom_range(0, 1));
            ex_redirect = ($urandom_range(0, 5) == 0);
            id_halt     = ($urandom_range(0, 11) == 0);
            mem_req     = 1'($urandom_range(0, 1));
            mem_ready   = ($urandom_range(0, 2) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
Name: pipeline_sequencer

Overview:
- Sequences the 5-stage RV32 pipeline (IF/ID/EX/MEM/WB) that the main decode controller feeds.
- Generates per-stage write enables and flushes for four cases: load-use hazards, EX-resolved redirects (taken branch, JAL, JALR), data-memory wait states and HALT drain.
- Owns the RUN/DRAIN/HALTED state machine and saturating stall/flush performance counters.
- Sits beside the decode controller; its outputs gate the PC and the pipeline registers.

Parameters:
- DRAIN_CYCLES, 3, cycles needed to retire the instructions in EX/MEM/WB after HALT is accepted in ID.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs1  in  5  rs1 field of the instruction in ID.
- id_rs2  in  5  rs2 field of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- id_halt  in  1  ID instruction decodes as HALT (opcode 7'b1111111).
- ex_memread  in  1  EX instruction is a load.
- ex_rd  in  5  destination register of the EX instruction.
- ex_redirect  in  1  taken branch, JAL or JALR resolved in EX.
- mem_req  in  1  MEM stage is issuing a data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC register update enable.
- ifid_write  out  1  IF/ID register update enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_flush  out  1  ID/EX loads a bubble (all control signals 0).
- pipe_hold  out  1  freezes ID/EX and EX/MEM.
- memwb_bubble  out  1  MEM/WB loads a bubble.
- halted  out  1  pipeline has fully drained after HALT.
- stall_count  out  CNT_W  cycles with pc_write=0 while in RUN.
- flush_count  out  CNT_W  redirect flushes taken.

Behaviour:
- State machine states: RUN, DRAIN, HALTED. Counters and drain_cnt are registered; all other outputs are combinational from state and inputs.
- Reset (synchronous):
  - state=RUN, drain_cnt=0, both counters 0.
  - While reset is high: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pipe_hold=0, memwb_bubble=1, halted=0.
- Default in RUN with no event: pc_write=1, ifid_write=1, all flushes, holds and bubbles 0.
- Events in RUN, highest priority first:
  1. mem_wait = mem_req & ~mem_ready: pc_write=0, ifid_write=0, pipe_hold=1, memwb_bubble=1, no flushes. All other events are ignored this cycle and re-evaluated the next cycle.
  2. ex_redirect: pc_write=1 (PC takes target), ifid_flush=1, idex_flush=1. A HALT or load-use hazard in ID is on the wrong path and is squashed. flush_count increments.
  3. id_halt: pc_write=0, ifid_write=0, idex_flush=1 (HALT itself never enters EX). Next state DRAIN, drain_cnt loads DRAIN_CYCLES-1.
  4. Load-use: ex_memread & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)). pc_write=0, ifid_write=0, idex_flush=1, for exactly 1 cycle per hazard; the next cycle re-evaluates with the load in MEM.
- stall_count increments on every RUN cycle with pc_write=0 (cases 1, 3, 4).
- Both counters saturate at all-ones.
- DRAIN:
  - pc_write=0, ifid_write=0, idex_flush=1.
  - mem_wait still applies: pipe_hold=1, memwb_bubble=1, drain_cnt frozen.
  - Otherwise drain_cnt decrements; DRAIN→HALTED on the cycle it is 0.
  - ex_redirect is ignored (older instructions cannot redirect past HALT in this ISA subset).
- HALTED: sticky until reset. pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, memwb_bubble=1, halted=1.
- DRAIN_CYCLES=1 is legal: DRAIN lasts one non-wait cycle. DRAIN_CYCLES=0 is illegal.
- Reset asserted in any state returns to RUN on the next edge; pending drains and counters are discarded.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 for one cycle → pc_write=0, ifid_write=0, idex_flush=1 that cycle; stall_count 0→1; defaults restored next cycle.
- Load to x0: ex_memread=1, ex_rd=0, id_rs1=0, id_uses_rs1=1 → no stall, pc_write=1.
- Redirect over hazard and halt: ex_redirect=1 with a load-use hazard and id_halt=1 → ifid_flush=1, idex_flush=1, pc_write=1; state stays RUN; flush_count=1.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles with ex_redirect=1 → pipe_hold=1, memwb_bubble=1, no flush for those 3 cycles; flush on the 4th cycle when mem_ready=1; stall_count=3.
- Halt drain: id_halt=1 with DRAIN_CYCLES=3 → DRAIN for 3 cycles, halted=1 on cycle 4. A single-cycle mem wait inserted mid-drain delays halted by exactly 1 cycle.
- Reset in HALTED: pulse reset for 1 cycle → halted=0, counters=0, pc_write=1 the cycle after reset deasserts.
